// File: rtl/arm_instr_encoder_if.sv
// Symbolic instruction stream into the LEGv8 encoder: one beat per valid/ready handshake.
interface arm_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [25:0] in_imm;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
        output in_ready
    );
endinterface

// File: rtl/arm_instr_encoder.sv
// Packs symbolic LEGv8 instructions into machine words and writes them to consecutive imem words.
// Define ARM_ENCODER_HALT_PAD_EN to append a B #0 halt word when a program is closed.
module arm_instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                finish,
    arm_instr_encoder_if.slave  bus,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                done,
    output logic                err
);
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       HALT_WORD = 32'h1400_0000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CLOSE
`ifdef ARM_ENCODER_HALT_PAD_EN
        , PAD
`endif
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W+1:0]   committed;
    logic                accept;
    logic                dt_fits;
    logic                cb_fits;
    logic                range_err;
    logic [31:0]         enc_word;

    // A write still in flight already owns a slot, so it counts against capacity.
    assign committed    = {1'b0, count} + {{(ADDR_W+1){1'b0}}, imem_we};
    assign full         = (count == DEPTH);
    assign bus.in_ready = (state == LOAD) && (committed < {1'b0, DEPTH});
    assign accept       = bus.in_valid && bus.in_ready;

    assign dt_fits = (&bus.in_imm[25:8])  || !(|bus.in_imm[25:8]);
    assign cb_fits = (&bus.in_imm[25:18]) || !(|bus.in_imm[25:18]);

    always_comb begin
        enc_word  = 32'h0;
        range_err = 1'b0;
        case (bus.in_op)
            3'd0: enc_word = {11'b10001011000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
            3'd1: enc_word = {11'b11001011000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
            3'd2: enc_word = {11'b10001010000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
            3'd3: enc_word = {11'b10101010000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
            3'd4: begin
                enc_word  = {11'b11111000010, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
                range_err = !dt_fits;
            end
            3'd5: begin
                enc_word  = {11'b11111000000, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
                range_err = !dt_fits;
            end
            3'd6: begin
                enc_word  = {8'b10110100, bus.in_imm[18:0], bus.in_rd};
                range_err = !cb_fits;
            end
            3'd7: enc_word = {6'b000101, bus.in_imm};
        endcase
    end

    // Accepted beats are registered for one write cycle; count follows the completed write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_addr    <= BASE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            if (imem_we) begin
                count <= count + (ADDR_W+1)'(1);
            end
            if (accept) begin
                imem_we    <= 1'b1;
                imem_addr  <= wr_addr;
                imem_wdata <= enc_word;
                wr_addr    <= wr_addr + ADDR_W'(1);
                if (range_err) begin
                    err <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        count   <= '0;
                        err     <= 1'b0;
                        wr_addr <= BASE;
                    end
                end
                LOAD: begin
                    if (finish) begin
                        state <= CLOSE;
                    end
                end
                CLOSE: begin
                    if (!imem_we) begin
`ifdef ARM_ENCODER_HALT_PAD_EN
                        if (!full) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wr_addr;
                            imem_wdata <= HALT_WORD;
                            wr_addr    <= wr_addr + ADDR_W'(1);
                            state      <= PAD;
                        end else begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
`else
                        done  <= 1'b1;
                        state <= IDLE;
`endif
                    end
                end
`ifdef ARM_ENCODER_HALT_PAD_EN
                PAD: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arm_instr_encoder.sv
// Scoreboard bench for arm_instr_encoder: directed beats push expected writes, a monitor pops them.
module tb_arm_instr_encoder;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic              is_done;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              finish;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;
    logic              err;

    exp_t exp_q[$];
    exp_t mon_item;
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_addr    = 0;

    arm_instr_encoder_if bus ();

    arm_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .finish     (finish),
        .bus        (bus),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Every write or done pulse must match the next scoreboard entry in order.
    always @(negedge clk) begin
        if (reset_n && (imem_we || done)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_output: got we=%0b done=%0b addr=%0d data=%08h, required no output",
                         imem_we, done, imem_addr, imem_wdata);
            end else begin
                mon_item = exp_q.pop_front();
                if (mon_item.is_done) begin
                    if (!done || imem_we) begin
                        miscompares++;
                        $display("[TB] FAIL done_pulse: got done=%0b we=%0b, required done=1 we=0", done, imem_we);
                    end
                end else if (!imem_we || done || imem_addr != mon_item.addr || imem_wdata != mon_item.data) begin
                    miscompares++;
                    $display("[TB] FAIL write: got we=%0b addr=%0d data=%08h, required we=1 addr=%0d data=%08h",
                             imem_we, imem_addr, imem_wdata, mon_item.addr, mon_item.data);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic expectClose();
`ifdef ARM_ENCODER_HALT_PAD_EN
        if (exp_addr < DEPTH) begin
            exp_q.push_back('{is_done: 1'b0, addr: ADDR_W'(exp_addr), data: 32'h1400_0000});
            exp_addr++;
        end
`endif
        exp_q.push_back('{is_done: 1'b1, addr: '0, data: '0});
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                 input logic [4:0] rm, input logic [25:0] imm, input logic [31:0] word,
                                 input bit fin, input bit track);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rn    = rn;
        bus.in_rm    = rm;
        bus.in_imm   = imm;
        while (!bus.in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ready_timeout: got in_ready=0 for %0d cycles, required 1", waited);
            bus.in_valid = 1'b0;
            return;
        end
        finish = fin;
        if (track) begin
            exp_q.push_back('{is_done: 1'b0, addr: ADDR_W'(exp_addr), data: word});
            exp_addr++;
        end
        if (fin) expectClose();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        finish       = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d outputs still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic doStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        exp_addr = 0;
    endtask

    logic [2:0]  fill_op   [6] = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd0, 3'd0};
    logic [31:0] fill_word [4] = '{32'h8A00_0000, 32'hAA01_0021, 32'h8A02_0042, 32'hAA03_0063};

    initial begin
        int k;
        bit rdy;
        reset_n      = 1'b0;
        start        = 1'b0;
        finish       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_rd    = '0;
        bus.in_rn    = '0;
        bus.in_rm    = '0;
        bus.in_imm   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_we", 32'(imem_we), 0);
        checkOutput("rst_addr", 32'(imem_addr), 0);
        checkOutput("rst_wdata", imem_wdata, 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_ready", 32'(bus.in_ready), 0);
        reset_n = 1'b1;

        // finish while idle must not produce done
        @(posedge clk);
        #1;
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_ready", 32'(bus.in_ready), 0);

        doStart();
        applyStimulus(3'd0, 5'd3, 5'd1, 5'd2, 26'd0, 32'h8B02_0023, 1'b1, 1'b1);
        waitDrain("add_drain");
        checkOutput("add_count", 32'(count), 32'(exp_addr));

        // start together with a valid beat in IDLE: no beat taken on that edge
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd4;
        bus.in_rd    = 5'd5;
        bus.in_rn    = 5'd2;
        bus.in_imm   = 26'd8;
        doStart();
        applyStimulus(3'd4, 5'd5, 5'd2, 5'd0, 26'd8, 32'hF840_8045, 1'b0, 1'b1);
        applyStimulus(3'd5, 5'd1, 5'd0, 5'd0, 26'd0, 32'hF800_0001, 1'b1, 1'b1);
        waitDrain("dt_drain");
        checkOutput("dt_count", 32'(count), 32'(exp_addr));

        doStart();
        applyStimulus(3'd6, 5'd4, 5'd0, 5'd0, 26'h3FF_FFFE, 32'hB4FF_FFC4, 1'b0, 1'b1);
        start = 1'b1;
        applyStimulus(3'd7, 5'd0, 5'd0, 5'd0, 26'd3, 32'h1400_0003, 1'b0, 1'b1);
        start = 1'b0;
        applyStimulus(3'd1, 5'd1, 5'd2, 5'd3, 26'd0, 32'hCB03_0041, 1'b1, 1'b1);
        waitDrain("cb_drain");
        checkOutput("cb_err", 32'(err), 0);
        checkOutput("cb_count", 32'(count), 32'(exp_addr));

        doStart();
        applyStimulus(3'd4, 5'd7, 5'd3, 5'd0, 26'd300, 32'hF852_C067, 1'b1, 1'b1);
        waitDrain("range_drain");
        checkOutput("err_set", 32'(err), 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_sticky", 32'(err), 1);
        doStart();
        checkOutput("err_cleared", 32'(err), 0);
        checkOutput("start_count", 32'(count), 0);

        // hold beats valid past capacity: only DEPTH may ever be written
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('{is_done: 1'b0, addr: ADDR_W'(i), data: fill_word[i]});
        end
        exp_addr = DEPTH;
        k = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = fill_op[k];
            bus.in_rd    = 5'(k);
            bus.in_rn    = 5'(k);
            bus.in_rm    = 5'(k);
            bus.in_imm   = '0;
            rdy          = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy && k < 5) k++;
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("full_beats", 32'(k), DEPTH);
        checkOutput("full_flag", 32'(full), 1);
        checkOutput("full_ready", 32'(bus.in_ready), 0);
        checkOutput("full_count", 32'(count), DEPTH);
        expectClose();
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        waitDrain("full_drain");

        // reset asserted while a write is in flight
        doStart();
        applyStimulus(3'd0, 5'd3, 5'd1, 5'd2, 26'd0, 32'h8B02_0023, 1'b0, 1'b1);
        applyStimulus(3'd0, 5'd6, 5'd1, 5'd2, 26'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("pre_rst_we", 32'(imem_we), 1);
        checkOutput("pre_rst_count", 32'(count), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_we", 32'(imem_we), 0);
        checkOutput("async_rst_count", 32'(count), 0);
        checkOutput("async_rst_addr", 32'(imem_addr), 0);
        checkOutput("async_rst_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        waitDrain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
